// File: rtl/vram_dma_m.sv
`default_nettype none
// ============================================================================
// Module   : vram_dma_m
// Brief    : CPU-side DMA copying an OBM (256 B) or PMF (512 B) image from
//            source RAM into the GPU VRAM write port, optionally vblank-gated.
// Revision : 1.0
// ============================================================================
module vram_dma_m #(
  parameter int                 SRC_ADDR_WIDTH = 16,
  parameter int                 VRAM_AW        = 12,
  parameter logic [VRAM_AW-1:0] OBM_BASE       = 12'h800,
  parameter logic [VRAM_AW-1:0] PMF_BASE       = 12'h000,
  parameter bit                 GATE_VBLANK    = 1'b1
) (
  input  logic                      cpu_clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      target,
  input  logic [SRC_ADDR_WIDTH-1:0] src_base,
  input  logic                      abort,
  input  logic                      vblank,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr,
  output logic                      src_rd_en,
  input  logic [7:0]                src_data,
  output logic [7:0]                data_out,
  output logic [VRAM_AW-1:0]        vram_address,
  output logic                      write_enable,
  output logic                      SELECT_pmf,
  output logic                      SELECT_obm,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      target_q, target_d;
  logic [SRC_ADDR_WIDTH-1:0] base_q, base_d;
  logic [9:0]                rd_idx_q, rd_idx_d;
  logic [9:0]                wr_idx_q, wr_idx_d;
  logic                      rd_pend_q, rd_pend_d;
  logic [1:0]                occ_q, occ_d;
  logic [7:0]                e0_q, e0_d;
  logic [7:0]                e1_q, e1_d;

  logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
  logic                      src_rd_en_q, src_rd_en_d;
  logic [7:0]                data_out_q, data_out_d;
  logic [VRAM_AW-1:0]        vram_address_q, vram_address_d;
  logic                      write_enable_q, write_enable_d;
  logic                      sel_pmf_q, sel_pmf_d;
  logic                      sel_obm_q, sel_obm_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [9:0] len;
  logic       gate;
  logic       run_ok;
  logic       head_vld;
  logic [7:0] head;
  logic       wr;
  logic       rd;
  logic       pop;
  logic       push;
  logic [2:0] fill;
  logic [1:0] slot;

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    base_d         = base_q;
    rd_idx_d       = rd_idx_q;
    wr_idx_d       = wr_idx_q;
    occ_d          = occ_q;
    e0_d           = e0_q;
    e1_d           = e1_q;
    src_addr_d     = src_addr_q;
    data_out_d     = data_out_q;
    vram_address_d = vram_address_q;
    src_rd_en_d    = 1'b0;
    write_enable_d = 1'b0;
    sel_pmf_d      = 1'b0;
    sel_obm_d      = 1'b0;
    rd_pend_d      = 1'b0;

    len    = target_q ? 10'd512 : 10'd256;
    gate   = vblank | ~GATE_VBLANK;
    run_ok = (state_q == S_RUN) && !abort;

    // Head of the skid buffer; bypass straight from src_data when empty.
    head_vld = (occ_q != 2'd0) || rd_pend_q;
    head     = (occ_q != 2'd0) ? e0_q : src_data;
    wr       = run_ok && gate && head_vld && (wr_idx_q != len);

    // Bytes that will be buffered or in flight after this edge bound the reads.
    fill = {1'b0, occ_q} + {2'b00, src_rd_en_q} + {2'b00, rd_pend_q} - {2'b00, wr};
    rd   = run_ok && gate && (rd_idx_q < len) && (fill < 3'd2);

    pop  = wr && (occ_q != 2'd0);
    push = run_ok && rd_pend_q && !(wr && (occ_q == 2'd0));
    slot = occ_q - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_RUN;
          target_d = target;
          base_d   = src_base;
          rd_idx_d = 10'd0;
          wr_idx_d = 10'd0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (wr_idx_q == len) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rd) begin
      src_rd_en_d = 1'b1;
      src_addr_d  = base_q + SRC_ADDR_WIDTH'(rd_idx_q);
      rd_idx_d    = rd_idx_q + 10'd1;
    end
    rd_pend_d = run_ok && src_rd_en_q;

    if (wr) begin
      write_enable_d = 1'b1;
      data_out_d     = head;
      vram_address_d = (target_q ? PMF_BASE : OBM_BASE) + VRAM_AW'(wr_idx_q);
      sel_pmf_d      = target_q;
      sel_obm_d      = !target_q;
      wr_idx_d       = wr_idx_q + 10'd1;
    end

    if (pop) begin
      e0_d = e1_q;
    end
    if (push) begin
      if (slot == 2'd0) begin
        e0_d = src_data;
      end else begin
        e1_d = src_data;
      end
    end
    occ_d = run_ok ? (slot + {1'b0, push}) : 2'd0;

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      target_q       <= 1'b0;
      base_q         <= '0;
      rd_idx_q       <= 10'd0;
      wr_idx_q       <= 10'd0;
      rd_pend_q      <= 1'b0;
      occ_q          <= 2'd0;
      e0_q           <= 8'd0;
      e1_q           <= 8'd0;
      src_addr_q     <= '0;
      src_rd_en_q    <= 1'b0;
      data_out_q     <= 8'd0;
      vram_address_q <= '0;
      write_enable_q <= 1'b0;
      sel_pmf_q      <= 1'b0;
      sel_obm_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      base_q         <= base_d;
      rd_idx_q       <= rd_idx_d;
      wr_idx_q       <= wr_idx_d;
      rd_pend_q      <= rd_pend_d;
      occ_q          <= occ_d;
      e0_q           <= e0_d;
      e1_q           <= e1_d;
      src_addr_q     <= src_addr_d;
      src_rd_en_q    <= src_rd_en_d;
      data_out_q     <= data_out_d;
      vram_address_q <= vram_address_d;
      write_enable_q <= write_enable_d;
      sel_pmf_q      <= sel_pmf_d;
      sel_obm_q      <= sel_obm_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign src_addr     = src_addr_q;
  assign src_rd_en    = src_rd_en_q;
  assign data_out     = data_out_q;
  assign vram_address = vram_address_q;
  assign write_enable = write_enable_q;
  assign SELECT_pmf   = sel_pmf_q;
  assign SELECT_obm   = sel_obm_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_dma_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_dma_m
// Brief    : Directed self-checking bench for vram_dma_m.
// Revision : 1.0
// ============================================================================
module tb_vram_dma_m;

  logic        cpu_clk;
  logic        rst;
  logic        start;
  logic        target;
  logic [15:0] src_base;
  logic        abort;
  logic        vblank;
  logic [15:0] src_addr;
  logic        src_rd_en;
  logic [7:0]  src_data;
  logic [7:0]  data_out;
  logic [11:0] vram_address;
  logic        write_enable;
  logic        SELECT_pmf;
  logic        SELECT_obm;
  logic        busy;
  logic        done;

  vram_dma_m dut (
    .cpu_clk      (cpu_clk),
    .rst          (rst),
    .start        (start),
    .target       (target),
    .src_base     (src_base),
    .abort        (abort),
    .vblank       (vblank),
    .src_addr     (src_addr),
    .src_rd_en    (src_rd_en),
    .src_data     (src_data),
    .data_out     (data_out),
    .vram_address (vram_address),
    .write_enable (write_enable),
    .SELECT_pmf   (SELECT_pmf),
    .SELECT_obm   (SELECT_obm),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Source RAM: one-cycle read latency.
  always @(posedge cpu_clk) begin
    if (src_rd_en) src_data <= src_byte(src_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  int          cyc = 0;
  logic        vb_s = 1'b0;
  logic [15:0] mon_base = 16'h0;
  logic        mon_tgt = 1'b0;
  int rcount, wcount, rd_err, addr_err, data_err, sel_err, we_low_err;
  int done_cnt, busy_err, first_rd, first_we;

  always @(posedge cpu_clk) begin
    cyc++;
    vb_s <= vblank;
  end

  always @(negedge cpu_clk) begin
    if (src_rd_en) begin
      if (src_addr !== mon_base + 16'(rcount)) rd_err++;
      if (first_rd < 0) first_rd = cyc;
      rcount++;
    end
    if (write_enable) begin
      if (vram_address !== ((mon_tgt ? 12'h000 : 12'h800) + 12'(wcount))) addr_err++;
      if (data_out !== src_byte(mon_base + 16'(wcount))) data_err++;
      if (!vb_s) we_low_err++;
      if (first_we < 0) first_we = cyc;
      wcount++;
    end
    if ((SELECT_pmf !== (write_enable & mon_tgt)) ||
        (SELECT_obm !== (write_enable & ~mon_tgt))) sel_err++;
    if (done) begin
      done_cnt++;
      if (!busy) busy_err++;
    end
  end

  task automatic clear_mon();
    rcount = 0; wcount = 0; rd_err = 0; addr_err = 0; data_err = 0;
    sel_err = 0; we_low_err = 0; done_cnt = 0; busy_err = 0;
    first_rd = -1; first_we = -1;
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_start(input logic tgt, input logic [15:0] base);
    clear_mon();
    mon_base = base;
    mon_tgt  = tgt;
    target   = tgt;
    src_base = base;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(done_cnt != 0), 64'd1);
    tick();
    tick();
  endtask

  task automatic wait_writes(input string tag, input int target_cnt, input int budget);
    int n = 0;
    while ((wcount + int'(write_enable)) < target_cnt && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'((wcount + int'(write_enable)) >= target_cnt), 64'd1);
  endtask

  task automatic check_full(input string tag, input int len);
    check({tag, "_wcount"}, 64'(wcount), 64'(len));
    check({tag, "_rcount"}, 64'(rcount), 64'(len));
    check({tag, "_errs"}, 64'(rd_err + addr_err + data_err + sel_err + busy_err), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({src_addr, src_rd_en, data_out, vram_address, write_enable,
                SELECT_pmf, SELECT_obm, busy, done});
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; target = 1'b0; src_base = 16'h0;
    abort = 1'b0; vblank = 1'b1;
    clear_mon();
    repeat (3) tick();
    check("reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    tick();

    // 1: OBM, vblank high throughout
    do_start(1'b0, 16'h0200);
    check("t1_busy_after_start", 64'(busy), 64'd1);
    wait_done("t1_done_timeout", 2000);
    check_full("t1", 256);
    check("t1_latency", 64'(first_we - first_rd), 64'd2);

    // 2: vblank gap after 100 writes
    do_start(1'b0, 16'h1234);
    wait_writes("t2_reach100", 100, 1000);
    vblank = 1'b0;
    repeat (40) tick();
    vblank = 1'b1;
    wait_done("t2_done_timeout", 2000);
    check_full("t2", 256);
    check("t2_we_while_low", 64'(we_low_err), 64'd0);

    // 3: PMF with source address wrap
    do_start(1'b1, 16'hFF80);
    wait_done("t3_done_timeout", 3000);
    check_full("t3", 512);

    // 4: abort after write 50, then a clean restart
    do_start(1'b0, 16'h0040);
    wait_writes("t4_reach50", 50, 1000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_we_after_abort", 64'(write_enable), 64'd0);
    check("t4_busy_after_abort", 64'(busy), 64'd0);
    repeat (20) tick();
    check("t4_wcount", 64'(wcount), 64'd50);
    check("t4_no_done", 64'(done_cnt), 64'd0);
    do_start(1'b0, 16'h0300);
    wait_done("t4r_done_timeout", 2000);
    check_full("t4r", 256);

    // 5: start while busy is ignored; start with vblank low waits
    do_start(1'b0, 16'h0500);
    repeat (10) tick();
    target = 1'b1; src_base = 16'h9999; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_done_timeout", 2000);
    repeat (600) tick();
    check_full("t5", 256);
    vblank = 1'b0;
    do_start(1'b1, 16'h0700);
    repeat (20) tick();
    check("t5_no_rd_low", 64'(rcount), 64'd0);
    check("t5_busy_low", 64'(busy), 64'd1);
    vblank = 1'b1;
    wait_done("t5b_done_timeout", 3000);
    check_full("t5b", 512);

    // 6: reset mid-transfer
    do_start(1'b0, 16'h0800);
    wait_writes("t6_reach30", 30, 1000);
    rst = 1'b1;
    tick();
    check("t6_outputs_after_rst", out_vec(), 64'd0);
    rst = 1'b0;
    tick();
    do_start(1'b1, 16'h0A00);
    wait_done("t6_done_timeout", 3000);
    check_full("t6", 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
